// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm clock's BCD time handling.
// The time is held as four BCD digits in HH:MM order, 24-hour format.
package alarm_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t MAX_MS_HR      = 4'd2;
   localparam bcd_digit_t MAX_LS_HR_AT_2 = 4'd3;
   localparam bcd_digit_t MAX_MS_MIN     = 4'd5;
   localparam bcd_digit_t MAX_BCD        = 4'd9;
   localparam bcd_digit_t RESET_DIGIT    = 4'd0;

   typedef struct packed {
      bcd_digit_t ms_hr;
      bcd_digit_t ls_hr;
      bcd_digit_t ms_min;
      bcd_digit_t ls_min;
   } bcd_time_t;

   localparam bcd_time_t RESET_TIME = '{
      ms_hr:  RESET_DIGIT,
      ls_hr:  RESET_DIGIT,
      ms_min: RESET_DIGIT,
      ls_min: RESET_DIGIT
   };

   function automatic logic digit_le(input bcd_digit_t d, input bcd_digit_t lim);
      return (d <= lim);
   endfunction

endpackage

// File: rtl/alarm_reg_bcd_time_validator.sv
// Combinational legality check for a candidate HH:MM time in BCD.
// Shared by the alarm load path and the clock-set path.
module bcd_time_validator
   import alarm_pkg::*;
(
   input  logic [3:0] i_ms_hr,
   input  logic [3:0] i_ls_hr,
   input  logic [3:0] i_ms_min,
   input  logic [3:0] i_ls_min,
   output logic       o_time_valid
);

   logic w_ms_hr_ok;
   logic w_ls_hr_ok;
   logic w_ms_min_ok;
   logic w_ls_min_ok;
   logic w_hr_is_20s;

   assign w_hr_is_20s = (i_ms_hr == MAX_MS_HR);

   assign w_ms_hr_ok  = digit_le(i_ms_hr, MAX_MS_HR);
   // In the 20s only 20..23 exist; otherwise the units digit is a full BCD digit.
   assign w_ls_hr_ok  = w_hr_is_20s ? digit_le(i_ls_hr, MAX_LS_HR_AT_2)
                                    : digit_le(i_ls_hr, MAX_BCD);
   assign w_ms_min_ok = digit_le(i_ms_min, MAX_MS_MIN);
   assign w_ls_min_ok = digit_le(i_ls_min, MAX_BCD);

   assign o_time_valid = w_ms_hr_ok & w_ls_hr_ok & w_ms_min_ok & w_ls_min_ok;

endmodule

// File: rtl/alarm_reg.sv
// Stored alarm time: a 16-bit BCD register loaded only with legal HH:MM values.
// Outputs come straight from flops, so there is no input-to-output path.
module alarm_reg
   import alarm_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] new_alarm_ms_hr,
   input  logic [3:0] new_alarm_ls_hr,
   input  logic [3:0] new_alarm_ms_min,
   input  logic [3:0] new_alarm_ls_min,
   input  logic       load_new_alarm,
   output logic [3:0] alarm_time_ms_hr,
   output logic [3:0] alarm_time_ls_hr,
   output logic [3:0] alarm_time_ms_min,
   output logic [3:0] alarm_time_ls_min
);

   bcd_time_t r_alarm_time;
   bcd_time_t w_candidate;
   logic      w_time_valid;
   logic      w_load_en;

   assign w_candidate = '{
      ms_hr:  new_alarm_ms_hr,
      ls_hr:  new_alarm_ls_hr,
      ms_min: new_alarm_ms_min,
      ls_min: new_alarm_ls_min
   };

   bcd_time_validator u_validator (
      .i_ms_hr      (new_alarm_ms_hr),
      .i_ls_hr      (new_alarm_ls_hr),
      .i_ms_min     (new_alarm_ms_min),
      .i_ls_min     (new_alarm_ls_min),
      .o_time_valid (w_time_valid)
   );

   // Illegal candidates are dropped silently so the stored time is always legal.
   assign w_load_en = load_new_alarm & w_time_valid;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_alarm_time <= RESET_TIME;
      end else if (w_load_en) begin
         r_alarm_time <= w_candidate;
      end
   end

   assign alarm_time_ms_hr  = r_alarm_time.ms_hr;
   assign alarm_time_ls_hr  = r_alarm_time.ls_hr;
   assign alarm_time_ms_min = r_alarm_time.ms_min;
   assign alarm_time_ls_min = r_alarm_time.ls_min;

endmodule

// File: tb/tb_alarm_reg.sv
// Directed bench for alarm_reg: expected HH:MM values are queued when stimulus
// is driven and popped when the outputs are sampled.
module tb_alarm_reg;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] new_alarm_ms_hr;
   logic [3:0] new_alarm_ls_hr;
   logic [3:0] new_alarm_ms_min;
   logic [3:0] new_alarm_ls_min;
   logic       load_new_alarm;
   logic [3:0] alarm_time_ms_hr;
   logic [3:0] alarm_time_ls_hr;
   logic [3:0] alarm_time_ms_min;
   logic [3:0] alarm_time_ls_min;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] sb[$];
   logic [15:0] model;

   alarm_reg dut (
      .clock             (clock),
      .reset             (reset),
      .new_alarm_ms_hr   (new_alarm_ms_hr),
      .new_alarm_ls_hr   (new_alarm_ls_hr),
      .new_alarm_ms_min  (new_alarm_ms_min),
      .new_alarm_ls_min  (new_alarm_ls_min),
      .load_new_alarm    (load_new_alarm),
      .alarm_time_ms_hr  (alarm_time_ms_hr),
      .alarm_time_ls_hr  (alarm_time_ls_hr),
      .alarm_time_ms_min (alarm_time_ms_min),
      .alarm_time_ls_min (alarm_time_ls_min)
   );

   always #5 clock = ~clock;

   // Legal if every digit is decimal, hours <= 23 and minutes <= 59.
   function automatic logic tb_valid(input logic [15:0] t);
      int hrs;
      int mins;
      if (t[15:12] > 9 || t[11:8] > 9 || t[7:4] > 9 || t[3:0] > 9) return 1'b0;
      hrs  = int'(t[15:12]) * 10 + int'(t[11:8]);
      mins = int'(t[7:4]) * 10 + int'(t[3:0]);
      return (hrs <= 23) && (mins <= 59);
   endfunction

   task automatic set_in(input logic [15:0] t, input logic ld);
      {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min} = t;
      load_new_alarm = ld;
   endtask

   task automatic expect_out(input logic [15:0] e);
      sb.push_back(e);
   endtask

   task automatic check(input string tag);
      logic [15:0] obs;
      logic [15:0] exp;
      obs = {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s: no expected value queued, observed %h", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
   endtask

   // Drive one cycle of stimulus at the falling edge, check just after the rising edge.
   task automatic step(input logic [15:0] t, input logic ld, input string tag);
      @(negedge clock);
      set_in(t, ld);
      if (reset) model = 16'h0000;
      else if (ld && tb_valid(t)) model = t;
      expect_out(model);
      @(posedge clock);
      #1;
      check(tag);
   endtask

   initial begin
      reset = 1'b1;
      model = 16'h0000;
      set_in(16'h0000, 1'b0);

      // 1: reset held for 120 ns
      #1;   expect_out(16'h0000); check("rst_early");
      #50;  expect_out(16'h0000); check("rst_mid");
      #60;  expect_out(16'h0000); check("rst_late");
      #9;   reset = 1'b0;
      step(16'h0000, 1'b0, "post_rst");

      // 2: load 06:45, then hold with strobe low and inputs moving
      step(16'h0645, 1'b1, "load_0645");
      step(16'h1111, 1'b0, "hold_0645_a");
      step(16'h2222, 1'b0, "hold_0645_b");

      // 3: overwrite, then asynchronous reset pulse between edges
      step(16'h1230, 1'b1, "load_1230");
      @(negedge clock);
      set_in(16'h1230, 1'b0);
      reset = 1'b1;
      model = 16'h0000;
      #1;   expect_out(model); check("async_rst");
      #8;   reset = 1'b0;
      step(16'h1230, 1'b0, "after_pulse");

      // 4: boundaries and rejected candidates
      step(16'h2359, 1'b1, "load_2359");
      step(16'h2400, 1'b1, "rej_2400");
      step(16'h1960, 1'b1, "rej_1960");
      step(16'h3000, 1'b1, "rej_3000");
      step(16'h2A00, 1'b1, "rej_ls_hr_A");
      step(16'h123A, 1'b1, "rej_ls_min_A");
      step(16'hF000, 1'b1, "rej_ms_hr_F");
      step(16'h1959, 1'b1, "load_1959");
      step(16'h2060, 1'b1, "rej_2060");
      step(16'h0000, 1'b1, "load_0000");
      step(16'h2359, 1'b1, "reload_2359");

      // 5: reset wins over a coincident load
      @(negedge clock);
      reset = 1'b1;
      step(16'h0815, 1'b1, "rst_vs_load");
      reset = 1'b0;
      set_in(16'h0815, 1'b0);
      step(16'h1745, 1'b0, "hold_after_rst");

      // 6: level-sensitive strobe tracks inputs
      step(16'h0100, 1'b1, "track_0100");
      step(16'h0200, 1'b1, "track_0200");
      step(16'h0300, 1'b1, "track_0300");
      step(16'h0300, 1'b0, "final_0300");

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $error("FAIL sb_drain: %0d expected values left, required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
